// File: rtl/pulse_gen.sv
// pulse_gen: programmable one-shot / burst / continuous pulse generator.
// High and low phase lengths are counted in clock cycles. Sequences are
// controlled with start/stop, and progress is reported on busy/done.
// Optional feature: define PULSE_GEN_COUNT_EN to add the pulse_count output,
// a saturating count of signal rising edges since the last start or reset.
module pulse_gen #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   high_len,
  input  logic [CNT_W-1:0]   low_len,
  input  logic [BURST_W-1:0] burst_len,
`ifdef PULSE_GEN_COUNT_EN
  output logic [BURST_W+CNT_W-1:0] pulse_count,
`endif
  output logic               signal,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [1:0] M_BURST = 2'b01;
  localparam logic [1:0] M_CONT  = 2'b10;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;       // cycles spent in the current phase
  logic [BURST_W-1:0] pcnt, pcnt_n;     // pulses started in this sequence
  logic [1:0]         mode_q, mode_n;
  logic [CNT_W-1:0]   h_q, h_n, l_q, l_n;
  logic [BURST_W-1:0] b_q, b_n;
  logic               done_n;

  // Next-state and latched-config logic; outputs are registered from state_n
  // so signal/busy change on the same edge that changes the phase.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pcnt_n  = pcnt;
    mode_n  = mode_q;
    h_n     = h_q;
    l_n     = l_q;
    b_n     = b_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        // stop beats start when both are present in IDLE
        if (start && !stop) begin
          mode_n  = mode;
          h_n     = (high_len  == '0) ? CNT_W'(1)   : high_len;
          l_n     = (low_len   == '0) ? CNT_W'(1)   : low_len;
          b_n     = (burst_len == '0) ? BURST_W'(1) : burst_len;
          state_n = HIGH;
          cnt_n   = CNT_W'(1);
          pcnt_n  = BURST_W'(1);
        end
      end
      HIGH: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          pcnt_n  = '0;
          done_n  = 1'b1;
        end else if (cnt == h_q) begin
          if ((mode_q == M_CONT) || ((mode_q == M_BURST) && (pcnt != b_q))) begin
            state_n = LOW;
            cnt_n   = CNT_W'(1);
          end else begin
            // last pulse ends here: no trailing low phase
            state_n = IDLE;
            cnt_n   = '0;
            pcnt_n  = '0;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      LOW: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          pcnt_n  = '0;
          done_n  = 1'b1;
        end else if (cnt == l_q) begin
          state_n = HIGH;
          cnt_n   = CNT_W'(1);
          pcnt_n  = pcnt + BURST_W'(1);  // wraps harmlessly in continuous mode
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        pcnt_n  = '0;
      end
    endcase
  end

  // State, counters, latched config and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      pcnt   <= '0;
      mode_q <= '0;
      h_q    <= '0;
      l_q    <= '0;
      b_q    <= '0;
      signal <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pcnt   <= pcnt_n;
      mode_q <= mode_n;
      h_q    <= h_n;
      l_q    <= l_n;
      b_q    <= b_n;
      signal <= (state_n == HIGH);
      busy   <= (state_n != IDLE);
      done   <= done_n;
    end
  end

`ifdef PULSE_GEN_COUNT_EN
  logic sig_d;
  logic accept;

  assign accept = (state == IDLE) && start && !stop;

  // Rising edges of the registered signal are seen one cycle late, so the
  // clear on the accepting edge does not swallow the first pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      sig_d       <= 1'b0;
      pulse_count <= '0;
    end else begin
      sig_d <= signal;
      if (accept)
        pulse_count <= '0;
      else if (signal && !sig_d && (pulse_count != '1))
        pulse_count <= pulse_count + 1'b1;
    end
  end
`endif

endmodule
